// File: rtl/tdm_demux_4_if.sv
// TDM receive bus: serial slot stream in, rebuilt parallel frame and status out.
interface tdm_demux_4_if #(
    parameter int W = 4
);
    logic [W-1:0] din;
    logic         din_valid;
    logic         sof;
    logic [W-1:0] y0;
    logic [W-1:0] y1;
    logic [W-1:0] y2;
    logic [W-1:0] y3;
    logic         frame_valid;
    logic [1:0]   slot;
    logic         locked;
    logic         sync_err;

    modport master (
        output din, din_valid, sof,
        input  y0, y1, y2, y3, frame_valid, slot, locked, sync_err
    );

    modport slave (
        input  din, din_valid, sof,
        output y0, y1, y2, y3, frame_valid, slot, locked, sync_err
    );
endinterface

// File: rtl/tdm_demux_4.sv
// 4-slot TDM demultiplexer: aligns on sof, stages slots 0..2 and publishes
// the whole frame together with a one-cycle frame_valid on the slot-3 beat.
module tdm_demux_4 #(
    parameter int W = 4
) (
    input logic          clk,
    input logic          rst,
    tdm_demux_4_if.slave bus
);
    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   slot_q, slot_d;
    logic [W-1:0] stage_q [3];
    logic [W-1:0] stage_d [3];
    logic [W-1:0] y_q [4];
    logic [W-1:0] y_d [4];
    logic         fv_q, fv_d;
    logic         se_q, se_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HUNT;
            slot_q  <= '0;
            stage_q <= '{default: '0};
            y_q     <= '{default: '0};
            fv_q    <= 1'b0;
            se_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            stage_q <= stage_d;
            y_q     <= y_d;
            fv_q    <= fv_d;
            se_q    <= se_d;
        end
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        stage_d = stage_q;
        y_d     = y_q;
        fv_d    = 1'b0;
        se_d    = 1'b0;

        if (bus.din_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (bus.sof) begin
                        stage_d[0] = bus.din;
                        slot_d     = 2'd1;
                        state_d    = LOCKED;
                    end
                end
                LOCKED: begin
                    // A misplaced sof outranks frame completion, even at slot 3.
                    if (bus.sof && (slot_q != 2'd0)) begin
                        se_d       = 1'b1;
                        stage_d[0] = bus.din;
                        slot_d     = 2'd1;
                    end else begin
                        unique case (slot_q)
                            2'd0: stage_d[0] = bus.din;
                            2'd1: stage_d[1] = bus.din;
                            2'd2: stage_d[2] = bus.din;
                            2'd3: begin
                                y_d[0] = stage_q[0];
                                y_d[1] = stage_q[1];
                                y_d[2] = stage_q[2];
                                y_d[3] = bus.din;
                                fv_d   = 1'b1;
                            end
                        endcase
                        slot_d = slot_q + 2'd1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    assign bus.y0          = y_q[0];
    assign bus.y1          = y_q[1];
    assign bus.y2          = y_q[2];
    assign bus.y3          = y_q[3];
    assign bus.frame_valid = fv_q;
    assign bus.sync_err    = se_q;
    assign bus.slot        = slot_q;
    assign bus.locked      = (state_q == LOCKED);
endmodule

// File: tb/tb_tdm_demux_4.sv
// Directed bench for tdm_demux_4: each task drives one scenario and checks inline.
module tb_tdm_demux_4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    tdm_demux_4_if #(.W(4)) bus ();

    tdm_demux_4 #(.W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are read there too.
    task automatic step(input logic [3:0] d, input logic s, input logic v);
        bus.din       = d;
        bus.sof       = s;
        bus.din_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(4'h0, 1'b0, 1'b0);
        n_cmp++;
        if ({bus.y0, bus.y1, bus.y2, bus.y3} !== 16'h0000) begin
            $display("FAIL reset_y: got %h want 0000", {bus.y0, bus.y1, bus.y2, bus.y3}); n_err++;
        end
        n_cmp++;
        if ({bus.frame_valid, bus.sync_err, bus.locked, bus.slot} !== 5'b0) begin
            $display("FAIL reset_flags: got fv=%b se=%b lk=%b slot=%0d want all 0",
                     bus.frame_valid, bus.sync_err, bus.locked, bus.slot); n_err++;
        end
    endtask

    task automatic test_single_frame();
        logic [3:0] vals [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(vals[i], i == 0, 1'b1);
            n_cmp++;
            if (bus.slot !== 2'((i + 1) % 4) || bus.locked !== 1'b1) begin
                $display("FAIL single_slot[%0d]: got slot=%0d lk=%b want slot=%0d lk=1",
                         i, bus.slot, bus.locked, (i + 1) % 4); n_err++;
            end
            n_cmp++;
            if (bus.frame_valid !== (i == 3)) begin
                $display("FAIL single_fv[%0d]: got %b want %b", i, bus.frame_valid, i == 3); n_err++;
            end
        end
        n_cmp++;
        if ({bus.y0, bus.y1, bus.y2, bus.y3} !== 16'hABCD) begin
            $display("FAIL single_y: got %h want abcd", {bus.y0, bus.y1, bus.y2, bus.y3}); n_err++;
        end
        step(4'h0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.frame_valid !== 1'b0 || {bus.y0, bus.y1, bus.y2, bus.y3} !== 16'hABCD) begin
            $display("FAIL single_hold: got fv=%b y=%h want fv=0 y=abcd",
                     bus.frame_valid, {bus.y0, bus.y1, bus.y2, bus.y3}); n_err++;
        end
    endtask

    task automatic test_hunt_discard();
        logic [3:0] vals [6] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
        int se_seen = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(vals[i], i == 2, 1'b1);
            se_seen += int'(bus.sync_err);
            if (i < 2) begin
                n_cmp++;
                if (bus.locked !== 1'b0 || bus.slot !== 2'd0) begin
                    $display("FAIL hunt_discard[%0d]: got lk=%b slot=%0d want lk=0 slot=0",
                             i, bus.locked, bus.slot); n_err++;
                end
            end
        end
        n_cmp++;
        if (bus.frame_valid !== 1'b1 || {bus.y0, bus.y1, bus.y2, bus.y3} !== 16'h3456) begin
            $display("FAIL hunt_y: got fv=%b y=%h want fv=1 y=3456",
                     bus.frame_valid, {bus.y0, bus.y1, bus.y2, bus.y3}); n_err++;
        end
        n_cmp++;
        if (se_seen !== 0) begin
            $display("FAIL hunt_sync_err: got %0d pulses want 0", se_seen); n_err++;
        end
    endtask

    task automatic test_gapped();
        logic [3:0] vals [8] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
        int         gaps [8] = '{0, 1, 2, 3, 3, 2, 1, 0};
        int fv_cnt = 0;
        int slot_bad = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(vals[i], i == 0, 1'b1);
            fv_cnt += int'(bus.frame_valid);
            if (bus.slot !== 2'((i + 1) % 4)) slot_bad++;
            if (i == 3) begin
                n_cmp++;
                if ({bus.y0, bus.y1, bus.y2, bus.y3} !== 16'h1234) begin
                    $display("FAIL gap_y1: got %h want 1234", {bus.y0, bus.y1, bus.y2, bus.y3}); n_err++;
                end
            end
            for (int g = 0; g < gaps[i]; g++) begin
                step(4'hF, 1'b1, 1'b0);
                fv_cnt += int'(bus.frame_valid);
                if (bus.slot !== 2'((i + 1) % 4)) slot_bad++;
            end
        end
        n_cmp++;
        if (slot_bad !== 0) begin
            $display("FAIL gap_slot: got %0d bad slot samples want 0", slot_bad); n_err++;
        end
        n_cmp++;
        if (fv_cnt !== 2) begin
            $display("FAIL gap_fv_count: got %0d want 2", fv_cnt); n_err++;
        end
        n_cmp++;
        if ({bus.y0, bus.y1, bus.y2, bus.y3} !== 16'h5678 || bus.sync_err !== 1'b0) begin
            $display("FAIL gap_y2: got y=%h se=%b want y=5678 se=0",
                     {bus.y0, bus.y1, bus.y2, bus.y3}, bus.sync_err); n_err++;
        end
    endtask

    task automatic test_resync();
        int fv_cnt = 0;
        do_reset();
        step(4'h1, 1'b1, 1'b1);
        step(4'h2, 1'b0, 1'b1);
        step(4'h9, 1'b1, 1'b1);
        n_cmp++;
        if (bus.sync_err !== 1'b1 || bus.frame_valid !== 1'b0 || bus.slot !== 2'd1) begin
            $display("FAIL resync_err: got se=%b fv=%b slot=%0d want se=1 fv=0 slot=1",
                     bus.sync_err, bus.frame_valid, bus.slot); n_err++;
        end
        n_cmp++;
        if ({bus.y0, bus.y1, bus.y2, bus.y3} !== 16'h0000 || bus.locked !== 1'b1) begin
            $display("FAIL resync_hold: got y=%h lk=%b want y=0000 lk=1",
                     {bus.y0, bus.y1, bus.y2, bus.y3}, bus.locked); n_err++;
        end
        step(4'hA, 1'b0, 1'b1);
        n_cmp++;
        if (bus.sync_err !== 1'b0) begin
            $display("FAIL resync_pulse: got se=%b want 0", bus.sync_err); n_err++;
        end
        fv_cnt += int'(bus.frame_valid);
        step(4'hB, 1'b0, 1'b1);
        fv_cnt += int'(bus.frame_valid);
        step(4'hC, 1'b0, 1'b1);
        fv_cnt += int'(bus.frame_valid);
        n_cmp++;
        if ({bus.y0, bus.y1, bus.y2, bus.y3} !== 16'h9ABC || fv_cnt !== 1) begin
            $display("FAIL resync_y: got y=%h fv_count=%0d want y=9abc fv_count=1",
                     {bus.y0, bus.y1, bus.y2, bus.y3}, fv_cnt); n_err++;
        end
        // sof landing on slot 3 must not complete the frame.
        step(4'h1, 1'b0, 1'b1);
        step(4'h2, 1'b0, 1'b1);
        step(4'h3, 1'b0, 1'b1);
        step(4'h7, 1'b1, 1'b1);
        n_cmp++;
        if (bus.sync_err !== 1'b1 || bus.frame_valid !== 1'b0 ||
            {bus.y0, bus.y1, bus.y2, bus.y3} !== 16'h9ABC) begin
            $display("FAIL resync_slot3: got se=%b fv=%b y=%h want se=1 fv=0 y=9abc",
                     bus.sync_err, bus.frame_valid, {bus.y0, bus.y1, bus.y2, bus.y3}); n_err++;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            step(4'(i), i == 1, 1'b1);
            n_cmp++;
            if (bus.frame_valid !== (i % 4 == 0)) begin
                $display("FAIL b2b_fv[cycle %0d]: got %b want %b", i, bus.frame_valid, i % 4 == 0); n_err++;
            end
            if (i % 4 == 0) begin
                n_cmp++;
                if ({bus.y0, bus.y1, bus.y2, bus.y3} !== {4'(i - 3), 4'(i - 2), 4'(i - 1), 4'(i)}) begin
                    $display("FAIL b2b_y[cycle %0d]: got %h want %h", i,
                             {bus.y0, bus.y1, bus.y2, bus.y3},
                             {4'(i - 3), 4'(i - 2), 4'(i - 1), 4'(i)}); n_err++;
                end
            end
        end
        step(4'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        step(4'h1, 1'b1, 1'b1);
        step(4'h2, 1'b0, 1'b1);
        step(4'h3, 1'b0, 1'b1);
        step(4'h4, 1'b0, 1'b1);
        step(4'h5, 1'b1, 1'b1);
        step(4'h6, 1'b0, 1'b1);
        n_cmp++;
        if ({bus.y0, bus.y1, bus.y2, bus.y3} !== 16'h1234 || bus.slot !== 2'd2) begin
            $display("FAIL midrst_pre: got y=%h slot=%0d want y=1234 slot=2",
                     {bus.y0, bus.y1, bus.y2, bus.y3}, bus.slot); n_err++;
        end
        bus.din_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.y0, bus.y1, bus.y2, bus.y3, bus.slot, bus.locked, bus.frame_valid, bus.sync_err} !== 21'b0) begin
            $display("FAIL midrst_async: got y=%h slot=%0d lk=%b fv=%b se=%b want all 0",
                     {bus.y0, bus.y1, bus.y2, bus.y3}, bus.slot, bus.locked,
                     bus.frame_valid, bus.sync_err); n_err++;
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(4'h7, 1'b0, 1'b1);
        step(4'h8, 1'b0, 1'b1);
        n_cmp++;
        if (bus.locked !== 1'b0 || bus.slot !== 2'd0) begin
            $display("FAIL midrst_hunt: got lk=%b slot=%0d want lk=0 slot=0", bus.locked, bus.slot); n_err++;
        end
        step(4'hE, 1'b1, 1'b1);
        n_cmp++;
        if (bus.locked !== 1'b1 || bus.slot !== 2'd1) begin
            $display("FAIL midrst_relock: got lk=%b slot=%0d want lk=1 slot=1", bus.locked, bus.slot); n_err++;
        end
    endtask

    initial begin
        bus.din       = '0;
        bus.sof       = 1'b0;
        bus.din_valid = 1'b0;
        test_reset();
        test_single_frame();
        test_hunt_discard();
        test_gapped();
        test_resync();
        test_back_to_back();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
